// File: rtl/plot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : plot_scheduler
//  Purpose  : Round-robin arbiter that shares the vga_adapter plot port among
//             several rectangle requesters and scans each winning rectangle
//             row-major at one pixel per clock, clipping off-screen pixels.
//             Optional macro PLOT_CLEAR_ON_RESET_EN adds a full-screen clear
//             sweep after reset.
//  Revision : 1.0  initial release
// ============================================================================
module plot_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] rect_x,
  input  logic [NUM_REQ*7-1:0] rect_y,
  input  logic [NUM_REQ*8-1:0] rect_w,
  input  logic [NUM_REQ*7-1:0] rect_h,
  input  logic [NUM_REQ*3-1:0] rect_colour,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef PLOT_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1, S_FIN = 2'd2, S_CLEAR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1, S_FIN = 2'd2} state_t;
`endif

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [7:0]      r_x0;
  logic [6:0]      r_y0;
  logic [7:0]      r_w;
  logic [6:0]      r_h;
  logic [2:0]      r_col;
  logic [7:0]      r_cx;
  logic [6:0]      r_cy;
`ifdef PLOT_CLEAR_ON_RESET_EN
  logic            r_clear_pend;
`endif

  logic [7:0] w_rx [NUM_REQ];
  logic [6:0] w_ry [NUM_REQ];
  logic [7:0] w_rw [NUM_REQ];
  logic [6:0] w_rh [NUM_REQ];
  logic [2:0] w_rc [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_rx[gi] = rect_x[8*gi +: 8];
      assign w_ry[gi] = rect_y[7*gi +: 7];
      assign w_rw[gi] = rect_w[8*gi +: 8];
      assign w_rh[gi] = rect_h[7*gi +: 7];
      assign w_rc[gi] = rect_colour[3*gi +: 3];
    end
  endgenerate

  // Lowest offset from the pointer wins, so scan offsets from the far end down.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [PW-1:0] p);
    logic [PW:0]   res;
    logic [PW-1:0] ix;
    int            idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NUM_REQ;
      ix  = PW'(idx);
      if (r[ix]) res = {1'b1, ix};
    end
    return res;
  endfunction

  logic [PW:0]   w_pick;
  logic          w_any;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_ptr_next;
  logic [7:0]    w_gx;
  logic [6:0]    w_gy;
  logic [7:0]    w_gw;
  logic [6:0]    w_gh;
  logic [2:0]    w_gc;
  logic          w_gzero;
  logic          w_gsingle;
  logic          w_gvis;

  always_comb begin
    w_pick     = rr_pick(req, r_ptr);
    w_any      = w_pick[PW];
    w_win      = w_pick[PW-1:0];
    w_ptr_next = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    w_gx       = w_rx[w_win];
    w_gy       = w_ry[w_win];
    w_gw       = w_rw[w_win];
    w_gh       = w_rh[w_win];
    w_gc       = w_rc[w_win];
    w_gzero    = (w_gw == 8'd0) || (w_gh == 7'd0);
    w_gsingle  = (w_gw == 8'd1) && (w_gh == 7'd1);
    w_gvis     = ({1'b0, w_gx} < 9'(SCREEN_W)) && ({1'b0, w_gy} < 8'(SCREEN_H));
  end

  // Next scan position; absolute coordinates are one bit wider so they never wrap.
  logic       w_row_end;
  logic [7:0] w_ncx;
  logic [6:0] w_ncy;
  logic       w_next_last;
  logic [8:0] w_nx;
  logic [7:0] w_ny;
  logic       w_nvis;

  always_comb begin
    w_row_end   = (r_cx == r_w - 8'd1);
    w_ncx       = w_row_end ? 8'd0 : r_cx + 8'd1;
    w_ncy       = w_row_end ? r_cy + 7'd1 : r_cy;
    w_next_last = (w_ncx == r_w - 8'd1) && (w_ncy == r_h - 7'd1);
    w_nx        = {1'b0, r_x0} + {1'b0, w_ncx};
    w_ny        = {1'b0, r_y0} + {1'b0, w_ncy};
    w_nvis      = (w_nx < 9'(SCREEN_W)) && (w_ny < 8'(SCREEN_H));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_col   <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      ack     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
`ifdef PLOT_CLEAR_ON_RESET_EN
      r_clear_pend <= 1'b1;
`endif
    end else begin
      ack  <= '0;
      done <= '0;
      plot <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef PLOT_CLEAR_ON_RESET_EN
          if (r_clear_pend) begin
            r_clear_pend <= 1'b0;
            r_state      <= S_CLEAR;
            busy         <= 1'b1;
            r_cx         <= '0;
            r_cy         <= '0;
            x            <= '0;
            y            <= '0;
            colour       <= '0;
            plot         <= 1'b1;
          end else
`endif
          if (w_any) begin
            r_ptr      <= w_ptr_next;
            r_owner    <= w_win;
            ack[w_win] <= 1'b1;
            busy       <= 1'b1;
            r_x0       <= w_gx;
            r_y0       <= w_gy;
            r_w        <= w_gw;
            r_h        <= w_gh;
            r_col      <= w_gc;
            r_cx       <= '0;
            r_cy       <= '0;
            if (w_gzero) begin
              r_state <= S_FIN;
            end else begin
              if (w_gvis) begin
                x      <= w_gx;
                y      <= w_gy;
                colour <= w_gc;
                plot   <= 1'b1;
              end
              r_state <= w_gsingle ? S_FIN : S_DRAW;
            end
          end
        end
        S_DRAW: begin
          r_cx <= w_ncx;
          r_cy <= w_ncy;
          if (w_nvis) begin
            x      <= w_nx[7:0];
            y      <= w_ny[6:0];
            colour <= r_col;
            plot   <= 1'b1;
          end
          if (w_next_last) r_state <= S_FIN;
        end
        S_FIN: begin
          done[r_owner] <= 1'b1;
          busy          <= 1'b0;
          r_state       <= S_IDLE;
        end
`ifdef PLOT_CLEAR_ON_RESET_EN
        S_CLEAR: begin
          if (r_cx == 8'(SCREEN_W - 1) && r_cy == 7'(SCREEN_H - 1)) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cx   <= (r_cx == 8'(SCREEN_W - 1)) ? 8'd0 : r_cx + 8'd1;
            r_cy   <= (r_cx == 8'(SCREEN_W - 1)) ? r_cy + 7'd1 : r_cy;
            x      <= (r_cx == 8'(SCREEN_W - 1)) ? 8'd0 : r_cx + 8'd1;
            y      <= (r_cx == 8'(SCREEN_W - 1)) ? r_cy + 7'd1 : r_cy;
            colour <= '0;
            plot   <= 1'b1;
          end
        end
`endif
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_plot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plot_scheduler
//  Purpose  : Directed and randomized bench for plot_scheduler against a
//             rectangle-level reference model (round-robin pick, row-major scan).
//  Revision : 1.0  initial release
// ============================================================================
module tb_plot_scheduler;
  localparam int N  = 4;
  localparam int SW = 160;
  localparam int SH = 120;

  logic           clk    = 1'b0;
  logic           resetn = 1'b1;
  logic [N-1:0]   req    = '0;
  logic [N*8-1:0] rect_x = '0;
  logic [N*7-1:0] rect_y = '0;
  logic [N*8-1:0] rect_w = '0;
  logic [N*7-1:0] rect_h = '0;
  logic [N*3-1:0] rect_colour = '0;
  logic [N-1:0]   ack;
  logic [N-1:0]   done;
  logic           busy;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic           plot;

  int total = 0;
  int bad   = 0;
  int mptr  = 0;
  int lx = 0, ly = 0, lc = 0;
  int fx[N], fy[N], fw[N], fh[N], fc[N];

  plot_scheduler #(.NUM_REQ(N), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .resetn(resetn), .req(req),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_colour(rect_colour),
    .ack(ack), .done(done), .busy(busy),
    .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rect(input int i, input int rx, input int ry, input int rw, input int rh, input int rc);
    fx[i] = rx; fy[i] = ry; fw[i] = rw; fh[i] = rh; fc[i] = rc;
    rect_x[8*i +: 8]      = 8'(rx);
    rect_y[7*i +: 7]      = 7'(ry);
    rect_w[8*i +: 8]      = 8'(rw);
    rect_h[7*i +: 7]      = 7'(rh);
    rect_colour[3*i +: 3] = 3'(rc);
  endtask

  task automatic rand_rect(input int i);
    int rx, ry;
    rx = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159);
    ry = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 119);
    set_rect(i, rx, ry, $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 7));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_colour"}, colour, 0);
    check({tag, "_plot"}, plot, 0);
  endtask

  // The screen-clear sweep only exists when the macro is defined.
  task automatic wait_clear();
`ifdef PLOT_CLEAR_ON_RESET_EN
    int cnt = 0;
    int cyc = 0;
    while (cyc < 19400 && !(cnt > 0 && !busy)) begin
      @(posedge clk); #1;
      cyc++;
      check("clear_ack", ack, 0);
      if (plot) begin
        check("clear_x", x, cnt % SW);
        check("clear_y", y, cnt / SW);
        check("clear_colour", colour, 0);
        cnt++;
      end
    end
    check("clear_count", cnt, SW * SH);
    check("clear_end_busy", busy, 0);
    lx = SW - 1; ly = SH - 1; lc = 0;
`endif
  endtask

  // Serve one grant: the model picks the winner from the request set seen at the next edge.
  task automatic serve(input bit keep);
    int win, px, py;
    win = -1;
    for (int j = 0; j < N; j++)
      if (win < 0 && req[(mptr + j) % N]) win = (mptr + j) % N;
    if (win < 0) begin
      check("serve_no_request", 1, 0);
      return;
    end
    mptr = (win + 1) % N;
    @(posedge clk); #1;
    check("ack", ack, 1 << win);
    check("busy_at_ack", busy, 1);
    if (!keep) req[win] = 1'b0;
    if (fw[win] == 0 || fh[win] == 0) begin
      check("zero_plot", plot, 0);
      check("zero_done_early", done, 0);
    end else begin
      for (int r = 0; r < fh[win]; r++) begin
        for (int c = 0; c < fw[win]; c++) begin
          if (!(r == 0 && c == 0)) begin
            @(posedge clk); #1;
            check("ack_quiet", ack, 0);
          end
          px = fx[win] + c;
          py = fy[win] + r;
          if (px < SW && py < SH) begin
            lx = px; ly = py; lc = fc[win];
            check("plot_on", plot, 1);
          end else begin
            check("plot_clipped", plot, 0);
          end
          check("pix_x", x, lx);
          check("pix_y", y, ly);
          check("pix_colour", colour, lc);
          check("done_early", done, 0);
        end
      end
    end
    @(posedge clk); #1;
    check("done", done, 1 << win);
    check("done_plot", plot, 0);
    check("done_ack", ack, 0);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_plot"}, plot, 0);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [N-1:0] m;

    // Reset, with requesters 0 and 2 raised before release.
    #2 resetn = 1'b0;
    #1 check_reset_outputs("reset");
    set_rect(0, 1, 2, 2, 1, 5);
    set_rect(2, 40, 50, 1, 2, 6);
    req = 4'b0101;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_hold");
    @(negedge clk) resetn = 1'b1;
    wait_clear();

    // Round robin between two held requesters: 0,2,0,2.
    for (int k = 0; k < 4; k++) serve(1'b1);
    req = '0;
    idle_check("rr_idle");

    // Single 3x2 rectangle on requester 1.
    set_rect(1, 10, 20, 3, 2, 2);
    req[1] = 1'b1;
    serve(1'b0);
    idle_check("single_idle");

    // Clipping at the bottom-right corner.
    set_rect(3, 158, 119, 4, 2, 5);
    req[3] = 1'b1;
    serve(1'b0);

    // Zero-size rectangle.
    set_rect(0, 30, 40, 0, 5, 1);
    req[0] = 1'b1;
    serve(1'b0);
    idle_check("zero_idle");

    // Randomized traffic: new requesters join while others wait for their grant.
    for (int k = 0; k < 40; k++) begin
      if (req == '0) begin
        m = 4'($urandom_range(1, 15));
        for (int i = 0; i < N; i++) if (m[i]) rand_rect(i);
        req = m;
      end else if ($urandom_range(0, 1) == 1) begin
        m = 4'($urandom_range(0, 15)) & ~req;
        for (int i = 0; i < N; i++) if (m[i]) rand_rect(i);
        req = req | m;
      end
      serve(1'b0);
    end
    req = '0;
    idle_check("rand_idle");

    // Asynchronous reset on the 3rd pixel of a 4x4 rectangle.
    set_rect(2, 5, 5, 4, 4, 6);
    req[2] = 1'b1;
    @(posedge clk); #1;
    check("mid_ack", ack, 4'b0100);
    req = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_third_x", x, 7);
    check("mid_third_y", y, 5);
    resetn = 1'b0;
    #1 check_reset_outputs("mid_reset");
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("mid_no_done", done, 0);
      check("mid_no_plot", plot, 0);
    end
    @(negedge clk) resetn = 1'b1;
    mptr = 0; lx = 0; ly = 0; lc = 0;
    wait_clear();

    // Fresh request after reset is served normally.
    set_rect(1, 100, 60, 2, 2, 7);
    req[1] = 1'b1;
    serve(1'b0);
    idle_check("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
